// File: rtl/pool_window_gen_pkg.sv
// Shared definitions for the 2x2 max-pool front end and its comparator:
// default geometry, pixel width and the window operand ordering.
package pool_window_gen_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 24;
  localparam int IMG_H_DEF  = 24;

  // Operand ordering of a window, shared with the pool comparator.
  typedef enum logic [1:0] {
    WIN_TL = 2'd0,
    WIN_TR = 2'd1,
    WIN_BL = 2'd2,
    WIN_BR = 2'd3
  } win_pos_e;

  localparam int WIN_N = 4;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One feature-map row of pixels. Written on even rows, read as an aligned
// column pair (col-1, col) on odd rows. Contents are not reset.
module pool_line_buf
  import pool_window_gen_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = cnt_w(IMG_W)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_col_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_col_i,
  output logic [DATA_W-1:0] rd_lo_o,
  output logic [DATA_W-1:0] rd_hi_o
);

  logic [DATA_W-1:0] mem_q [IMG_W];
  logic [AW-1:0]     lo_idx;

  // Reads only matter on odd columns, so col-1 is col with bit 0 cleared;
  // this keeps the index in range when col is 0.
  assign lo_idx  = rd_col_i & ~AW'(1);
  assign rd_lo_o = mem_q[lo_idx];
  assign rd_hi_o = mem_q[rd_col_i];

  // Single write port, no reset on storage.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_col_i] <= wr_data_i;
  end

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 window generator: raster pixels in, registered
// non-overlapping 2x2 windows out.
// Handshake: a transfer happens on a rising edge where valid && ready;
// in_ready = !win_valid || win_ready, so input stalls while a window waits.
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic              win_last
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] bl_q, bl_d;
  logic [DATA_W-1:0] win_q [WIN_N];
  logic [DATA_W-1:0] win_d [WIN_N];
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;
  logic              accept, load, buf_we;
  logic [DATA_W-1:0] buf_lo, buf_hi;

  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;
  // Even rows fill the line buffer; odd rows pair with it.
  assign buf_we   = accept && !row_q[0];
  assign load     = accept && row_q[0] && col_q[0];

  pool_line_buf #(
    .IMG_W  (IMG_W),
    .DATA_W (DATA_W),
    .AW     (CW)
  ) u_line_buf (
    .clk_i     (clk),
    .wr_en_i   (buf_we),
    .wr_col_i  (col_q),
    .wr_data_i (in_data),
    .rd_col_i  (col_q),
    .rd_lo_o   (buf_lo),
    .rd_hi_o   (buf_hi)
  );

  // Raster position: col wraps into row, row wraps at end of frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Bottom-left hold and window output register with valid tracking.
  always_comb begin
    bl_d = bl_q;
    for (int i = 0; i < WIN_N; i++) win_d[i] = win_q[i];
    win_last_d  = win_last_q;
    win_valid_d = win_valid_q && !win_ready;
    if (accept && row_q[0] && !col_q[0]) bl_d = in_data;
    if (load) begin
      win_d[WIN_TL] = buf_lo;
      win_d[WIN_TR] = buf_hi;
      win_d[WIN_BL] = bl_q;
      win_d[WIN_BR] = in_data;
      win_last_d    = (row_q == ROW_MAX) && (col_q == COL_MAX);
      win_valid_d   = 1'b1;
    end
  end

  // State registers; reset drops any partial frame and held window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      bl_q        <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      bl_q        <= bl_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= win_d[i];
    end
  end

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign win0      = win_q[WIN_TL];
  assign win1      = win_q[WIN_TR];
  assign win2      = win_q[WIN_BL];
  assign win3      = win_q[WIN_BR];

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: a 4x4 instance for directed and table cases,
// a 24x24 instance for randomized handshakes against a frame model.
module tb_pool_window_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- 4x4 instance ----------------
  logic       s_in_valid, s_in_ready, s_win_valid, s_win_ready, s_win_last;
  logic [7:0] s_in_data, s_win0, s_win1, s_win2, s_win3;

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .win_valid(s_win_valid), .win_ready(s_win_ready),
    .win0(s_win0), .win1(s_win1), .win2(s_win2), .win3(s_win3),
    .win_last(s_win_last)
  );

  // ---------------- 24x24 instance ----------------
  logic       l_in_valid, l_in_ready, l_win_valid, l_win_ready, l_win_last;
  logic [7:0] l_in_data, l_win0, l_win1, l_win2, l_win3;

  pool_window_gen #(.IMG_W(24), .IMG_H(24), .DATA_W(8)) dut_l (
    .clk(clk), .rst_n(rst_n),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
    .win_valid(l_win_valid), .win_ready(l_win_ready),
    .win0(l_win0), .win1(l_win1), .win2(l_win2), .win3(l_win3),
    .win_last(l_win_last)
  );

  // ---------------- scoreboard state ----------------
  int errs = 0;
  int checks = 0;
  int s_last_cnt = 0;
  int l_win_cnt = 0;
  logic [32:0] s_exp_q[$];
  logic [32:0] l_exp_q[$];
  logic [32:0] s_mon_e, l_mon_e;
  logic [7:0]  s_pix [16];
  logic [7:0]  l_pix [576];

  typedef struct packed {
    logic [7:0]  tl;
    logic [7:0]  tr;
    logic [7:0]  bl;
    logic [7:0]  br;
    logic [31:0] want;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [32:0] mk(input logic l, input logic [7:0] a, b, c, d);
    return {l, a, b, c, d};
  endfunction

  // Frame model: window (r,c) covers rows 2r..2r+1, cols 2c..2c+1.
  task automatic model_s(input int nwin);
    int k = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        if (k < nwin)
          s_exp_q.push_back(mk(r == 1 && c == 1,
            s_pix[2*r*4 + 2*c], s_pix[2*r*4 + 2*c + 1],
            s_pix[(2*r+1)*4 + 2*c], s_pix[(2*r+1)*4 + 2*c + 1]));
        k++;
      end
  endtask

  task automatic model_l();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++)
        l_exp_q.push_back(mk(r == 11 && c == 11,
          l_pix[2*r*24 + 2*c], l_pix[2*r*24 + 2*c + 1],
          l_pix[(2*r+1)*24 + 2*c], l_pix[(2*r+1)*24 + 2*c + 1]));
  endtask

  // ---------------- monitors (sample on falling edge) ----------------
  always @(negedge clk) begin
    if (rst_n && s_win_valid && s_win_ready) begin
      if (s_exp_q.size() == 0) chk("s_win_extra", 64'd1, 64'd0);
      else begin
        s_mon_e = s_exp_q.pop_front();
        chk("s_win", 64'({s_win_last, s_win0, s_win1, s_win2, s_win3}), 64'(s_mon_e));
      end
      if (s_win_last) s_last_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && l_win_valid && l_win_ready) begin
      if (l_exp_q.size() == 0) chk("l_win_extra", 64'd1, 64'd0);
      else begin
        l_mon_e = l_exp_q.pop_front();
        chk("l_win", 64'({l_win_last, l_win0, l_win1, l_win2, l_win3}), 64'(l_mon_e));
      end
      l_win_cnt++;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic s_send(input logic [7:0] v);
    int n = 0;
    s_in_valid = 1'b1;
    s_in_data  = v;
    @(negedge clk);
    while (!s_in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("s_send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
  endtask

  task automatic s_drain(input string nm);
    int n = 0;
    while ((s_exp_q.size() != 0 || s_win_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 64'(s_exp_q.size()), 64'd0);
  endtask

  task automatic s_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(s_win_valid), 64'd0);
    chk("rst_async_ready", 64'(s_in_ready), 64'd1);
    s_exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  int  l_idx, l_guard, l_base;
  bit  l_done;
  logic exp_v;

  // ---------------- main test ----------------
  initial begin
    vecs[0] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 32'h807FFF00};
    vecs[1] = '{8'h7F, 8'h80, 8'h00, 8'hFF, 32'h7F8000FF};
    vecs[2] = '{8'h01, 8'hFE, 8'h81, 8'h7E, 32'h01FE817E};
    vecs[3] = '{8'hAA, 8'h55, 8'hC3, 8'h3C, 32'hAA55C33C};

    rst_n = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_win_ready = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_valid", 64'(s_win_valid), 64'd0);
    chk("rst_s_last",  64'(s_win_last), 64'd0);
    chk("rst_s_ready", 64'(s_in_ready), 64'd1);
    chk("rst_s_win",   64'({s_win0, s_win1, s_win2, s_win3}), 64'd0);
    chk("rst_l_valid", 64'(l_win_valid), 64'd0);
    chk("rst_l_ready", 64'(l_in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 4x4 ramp with per-pixel latency checks.
    for (int i = 0; i < 16; i++) s_pix[i] = 8'(i);
    model_s(4);
    for (int i = 0; i < 16; i++) begin
      s_send(s_pix[i]);
      exp_v = (i == 5 || i == 7 || i == 13 || i == 15);
      chk("lat_valid", 64'(s_win_valid), 64'(exp_v));
      if (exp_v) chk("lat_last", 64'(s_win_last), 64'(i == 15));
    end
    s_drain("ramp_drain");

    // Table of signed extreme patterns in the first window.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) s_pix[i] = 8'(i + 16 * v);
      s_pix[0] = vecs[v].tl; s_pix[1] = vecs[v].tr;
      s_pix[4] = vecs[v].bl; s_pix[5] = vecs[v].br;
      model_s(4);
      for (int i = 0; i < 16; i++) begin
        s_send(s_pix[i]);
        if (i == 5) chk("tbl_win", 64'({s_win0, s_win1, s_win2, s_win3}), 64'(vecs[v].want));
      end
      s_drain("tbl_drain");
    end

    // Backpressure for 5 cycles after the first window.
    for (int i = 0; i < 16; i++) s_pix[i] = 8'(i);
    model_s(4);
    for (int i = 0; i < 6; i++) s_send(s_pix[i]);
    s_win_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = s_pix[6];
      @(negedge clk);
      chk("bp_in_ready", 64'(s_in_ready), 64'd0);
      chk("bp_valid", 64'(s_win_valid), 64'd1);
      chk("bp_hold", 64'({s_win0, s_win1, s_win2, s_win3}), 64'h00010405);
      @(posedge clk);
      #1;
    end
    s_win_ready = 1'b1;
    for (int i = 6; i < 16; i++) s_send(s_pix[i]);
    s_drain("bp_drain");

    // Reset after 9 pixels.
    model_s(2);
    for (int i = 0; i < 9; i++) s_send(s_pix[i]);
    chk("rst9_consumed", 64'(s_exp_q.size()), 64'd0);
    s_reset_pulse();

    // Reset while a window is held.
    for (int i = 0; i < 5; i++) s_send(s_pix[i]);
    s_win_ready = 1'b0;
    s_send(s_pix[5]);
    chk("held_valid", 64'(s_win_valid), 64'd1);
    chk("held_win", 64'({s_win0, s_win1, s_win2, s_win3}), 64'h00010405);
    s_reset_pulse();
    chk("held_rst_last", 64'(s_win_last), 64'd0);
    chk("held_rst_win", 64'({s_win0, s_win1, s_win2, s_win3}), 64'd0);
    s_win_ready = 1'b1;
    model_s(4);
    for (int i = 0; i < 16; i++) s_send(s_pix[i]);
    s_drain("post_rst_drain");

    // Two back-to-back frames.
    l_base = s_last_cnt;
    model_s(4);
    for (int i = 0; i < 16; i++) s_send(s_pix[i]);
    for (int i = 0; i < 16; i++) s_pix[i] = 8'(100 + i);
    model_s(4);
    for (int i = 0; i < 16; i++) s_send(s_pix[i]);
    s_drain("b2b_drain");
    chk("b2b_last_cnt", 64'(s_last_cnt - l_base), 64'd2);

    // Random 24x24 frame with 50% valid and ready.
    for (int i = 0; i < 576; i++) l_pix[i] = 8'($urandom);
    model_l();
    l_base  = l_win_cnt;
    l_idx   = 0;
    l_guard = 0;
    l_done  = 1'b0;
    fork
      begin
        while (l_idx < 576 && l_guard < 20000) begin
          l_in_valid = 1'($urandom_range(0, 1));
          l_in_data  = l_pix[l_idx];
          @(negedge clk);
          if (l_in_valid && l_in_ready) l_idx++;
          @(posedge clk);
          #1;
          l_guard++;
        end
        l_in_valid = 1'b0;
        l_done = 1'b1;
      end
      begin
        while (!l_done) begin
          l_win_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        l_win_ready = 1'b1;
      end
    join
    chk("l_all_sent", 64'(l_idx), 64'd576);
    l_guard = 0;
    while ((l_exp_q.size() != 0 || l_win_valid) && l_guard < 2000) begin
      @(posedge clk);
      #1;
      l_guard++;
    end
    chk("l_drain", 64'(l_exp_q.size()), 64'd0);
    chk("l_win_count", 64'(l_win_cnt - l_base), 64'd144);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
